integrity_status_monitor: RTL and testbench

Parametrised status/alarm monitor for the FPGA top level; successor to the fixed reset-counter, illegal-instruction and exit latches that drive the board LEDs. Accepts N_ALARM integrity alarm lines (illegal instruction, tag mismatch, patch fault, ...), applies a post-reset blanking window, and keeps sticky flags, saturating per-channel counters and a first-alarm record (channel id and PC). Also latches program exit and drives an 8-bit LED bank through a selectable display mode. Runs entirely in the core clock domain.

---
 rtl/integrity_status_monitor.sv | 178 +++++++++++++++++
 tb/tb_integrity_status_monitor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/integrity_status_monitor.sv
// Integrity status monitor for the FPGA top level.
// Qualifies alarm lines after a post-reset blanking window, keeps sticky flags,
// saturating per-channel counters and a first-alarm record, latches program exit,
// and drives a registered 8-bit LED bank through a selectable display mode.
module integrity_status_monitor #(
  parameter int N_ALARM      = 4,
  parameter int BLANK_CYCLES = 7,
  parameter int CNT_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 16,
  localparam int ID_WIDTH    = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic                           clk_core_slow_i,
  input  logic                           rst_i,
  input  logic [N_ALARM-1:0]             alarm_i,
  input  logic                           clear_i,
  input  logic [ADDR_WIDTH-1:0]          instr_addr_i,
  input  logic                           exit_valid_i,
  input  logic [31:0]                    exit_value_i,
  input  logic [1:0]                     mode_i,
  output logic                           armed_o,
  output logic [N_ALARM-1:0]             alarm_sticky_o,
  output logic [N_ALARM*CNT_WIDTH-1:0]   alarm_cnt_o,
  output logic                           first_valid_o,
  output logic [ID_WIDTH-1:0]            first_id_o,
  output logic [ADDR_WIDTH-1:0]          first_addr_o,
  output logic                           exit_valid_o,
  output logic [31:0]                    exit_value_o,
  output logic [7:0]                     led_o
);

  // Counter must be able to hold BLANK_CYCLES itself, where it parks.
  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam int N_NIB   = ADDR_WIDTH / 4;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [BLANK_W-1:0]           blank_cnt_reg;
  logic                         armed;
  logic [N_ALARM-1:0]           alarm_q;
  logic                         any_q;
  logic [N_ALARM-1:0]           sticky_flat;
  logic [N_ALARM*CNT_WIDTH-1:0] cnt_flat;

  logic                         first_valid_reg;
  logic [ID_WIDTH-1:0]          first_id_reg;
  logic [ID_WIDTH-1:0]          first_id_next;
  logic [ADDR_WIDTH-1:0]        first_addr_reg;

  logic                         exit_valid_reg;
  logic [31:0]                  exit_value_reg;

  logic [ADDR_WIDTH-1:0]        addr_masked;
  logic [3:0]                   addr_fold;
  logic [CNT_WIDTH-1:0]         sel_cnt;
  logic [7:0]                   led_reg;
  logic [7:0]                   led_next;

  // Armed once the blanking counter has parked at BLANK_CYCLES.
  assign armed   = (blank_cnt_reg == BLANK_W'(BLANK_CYCLES));
  assign alarm_q = alarm_i & {N_ALARM{armed}};
  assign any_q   = |alarm_q;

  // Blanking counter: counts up after reset release and then holds; clear does not touch it.
  always_ff @(posedge clk_core_slow_i) begin
    if (rst_i) begin
      blank_cnt_reg <= '0;
    end else if (!armed) begin
      blank_cnt_reg <= blank_cnt_reg + BLANK_W'(1);
    end
  end

  // Per-channel sticky flag and saturating level counter.
  generate
    for (genvar gi = 0; gi < N_ALARM; gi++) begin : g_chan
      logic                 sticky_reg;
      logic [CNT_WIDTH-1:0] cnt_reg;

      // Clear beats a coincident alarm; counter stops at all-ones instead of wrapping.
      always_ff @(posedge clk_core_slow_i) begin
        if (rst_i || clear_i) begin
          sticky_reg <= 1'b0;
          cnt_reg    <= '0;
        end else if (alarm_q[gi]) begin
          sticky_reg <= 1'b1;
          if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
          end
        end
      end

      assign sticky_flat[gi]                          = sticky_reg;
      assign cnt_flat[gi*CNT_WIDTH +: CNT_WIDTH]      = cnt_reg;
    end
  endgenerate

  // Lowest qualified channel index wins when several fire together.
  always_comb begin
    first_id_next = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (alarm_q[i]) begin
        first_id_next = ID_WIDTH'(i);
      end
    end
  end

  // First-alarm record: captured once, frozen until clear or reset.
  always_ff @(posedge clk_core_slow_i) begin
    if (rst_i || clear_i) begin
      first_valid_reg <= 1'b0;
      first_id_reg    <= '0;
      first_addr_reg  <= '0;
    end else if (any_q && !first_valid_reg) begin
      first_valid_reg <= 1'b1;
      first_id_reg    <= first_id_next;
      first_addr_reg  <= instr_addr_i;
    end
  end

  // Exit latch: only the first strobe after reset is kept.
  always_ff @(posedge clk_core_slow_i) begin
    if (rst_i) begin
      exit_valid_reg <= 1'b0;
      exit_value_reg <= '0;
    end else if (exit_valid_i && !exit_valid_reg) begin
      exit_valid_reg <= 1'b1;
      exit_value_reg <= exit_value_i;
    end
  end

  // Word-aligned fetch address folded into one nibble by XOR.
  always_comb begin
    addr_masked = instr_addr_i & ~ADDR_WIDTH'(3);
    addr_fold   = 4'h0;
    for (int i = 0; i < N_NIB; i++) begin
      addr_fold = addr_fold ^ addr_masked[i*4 +: 4];
    end
  end

  // Counter of the recorded first channel, looked up without out-of-range indexing.
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < N_ALARM; i++) begin
      if (first_id_reg == ID_WIDTH'(i)) begin
        sel_cnt = cnt_flat[i*CNT_WIDTH +: CNT_WIDTH];
      end
    end
  end

  // LED source selection from current state; registered below so the bank never glitches.
  always_comb begin
    led_next = 8'h00;
    case (mode_i)
      2'd0:    led_next = {~armed, exit_valid_reg, first_valid_reg, |sticky_flat, addr_fold};
      2'd1:    led_next = 8'(sticky_flat);
      2'd2:    led_next = first_valid_reg ? 8'(sel_cnt) : 8'h00;
      default: led_next = exit_value_reg[7:0];
    endcase
  end

  // LED bank register.
  always_ff @(posedge clk_core_slow_i) begin
    if (rst_i) begin
      led_reg <= 8'h00;
    end else begin
      led_reg <= led_next;
    end
  end

  assign armed_o        = armed;
  assign alarm_sticky_o = sticky_flat;
  assign alarm_cnt_o    = cnt_flat;
  assign first_valid_o  = first_valid_reg;
  assign first_id_o     = first_id_reg;
  assign first_addr_o   = first_addr_reg;
  assign exit_valid_o   = exit_valid_reg;
  assign exit_value_o   = exit_value_reg;
  assign led_o          = led_reg;

endmodule

// File: tb/tb_integrity_status_monitor.sv
// Bench for integrity_status_monitor: cycle model compared every cycle, plus directed literal checks.
module tb_integrity_status_monitor;

  localparam int N  = 4;
  localparam int BL = 7;
  localparam int CW = 4;
  localparam int AW = 16;
  localparam int IW = 2;

  logic              clk_core_slow_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [N-1:0]      alarm_i = '0;
  logic              clear_i = 1'b0;
  logic [AW-1:0]     instr_addr_i = '0;
  logic              exit_valid_i = 1'b0;
  logic [31:0]       exit_value_i = '0;
  logic [1:0]        mode_i = 2'd0;
  logic              armed_o;
  logic [N-1:0]      alarm_sticky_o;
  logic [N*CW-1:0]   alarm_cnt_o;
  logic              first_valid_o;
  logic [IW-1:0]     first_id_o;
  logic [AW-1:0]     first_addr_o;
  logic              exit_valid_o;
  logic [31:0]       exit_value_o;
  logic [7:0]        led_o;

  integrity_status_monitor #(
    .N_ALARM(N), .BLANK_CYCLES(BL), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)
  ) dut (
    .clk_core_slow_i(clk_core_slow_i),
    .rst_i(rst_i),
    .alarm_i(alarm_i),
    .clear_i(clear_i),
    .instr_addr_i(instr_addr_i),
    .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i),
    .mode_i(mode_i),
    .armed_o(armed_o),
    .alarm_sticky_o(alarm_sticky_o),
    .alarm_cnt_o(alarm_cnt_o),
    .first_valid_o(first_valid_o),
    .first_id_o(first_id_o),
    .first_addr_o(first_addr_o),
    .exit_valid_o(exit_valid_o),
    .exit_value_o(exit_value_o),
    .led_o(led_o)
  );

  always #5 clk_core_slow_i = ~clk_core_slow_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit            m_valid = 1'b0;
  int            m_since;
  bit [N-1:0]    m_sticky;
  int            m_cnt [N];
  bit            m_fv;
  int            m_fid;
  logic [AW-1:0] m_faddr;
  bit            m_ev;
  logic [31:0]   m_eval;
  logic [7:0]    m_led;

  // Inputs as seen at the last rising edge
  logic          s_rst, s_clear, s_ev;
  logic [N-1:0]  s_alarm;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_eval;
  logic [1:0]    s_mode;

  task automatic model_step();
    logic [AW-1:0] a;
    logic [7:0]    led_n;
    int            fold;
    bit            armed;
    if (s_rst) begin
      m_valid = 1'b1; m_since = 0; m_sticky = '0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
      m_fv = 1'b0; m_fid = 0; m_faddr = '0; m_ev = 1'b0; m_eval = '0; m_led = 8'h00;
      return;
    end
    if (!m_valid) return;
    armed = (m_since >= BL);
    led_n = 8'h00;
    case (s_mode)
      2'd0: begin
        a = s_addr & ~16'h0003;
        fold = 0;
        for (int i = 0; i < AW / 4; i++) fold = fold ^ int'(a[4*i +: 4]);
        led_n = {~armed, m_ev, m_fv, |m_sticky, fold[3:0]};
      end
      2'd1: led_n = 8'(m_sticky);
      2'd2: led_n = m_fv ? 8'(m_cnt[m_fid]) : 8'h00;
      default: led_n = m_eval[7:0];
    endcase
    m_led = led_n;
    m_since++;
    if (s_clear) begin
      m_sticky = '0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
      m_fv = 1'b0; m_fid = 0; m_faddr = '0;
    end else if (armed) begin
      for (int k = 0; k < N; k++) begin
        if (s_alarm[k]) begin
          m_sticky[k] = 1'b1;
          if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
        end
      end
      if (!m_fv && s_alarm != 0) begin
        m_fv = 1'b1;
        m_faddr = s_addr;
        for (int k = N - 1; k >= 0; k--) if (s_alarm[k]) m_fid = k;
      end
    end
    if (s_ev && !m_ev) begin
      m_ev = 1'b1;
      m_eval = s_eval;
    end
  endtask

  task automatic compare_all();
    logic [N*CW-1:0] mc;
    for (int k = 0; k < N; k++) mc[k*CW +: CW] = CW'(m_cnt[k]);
    chk("m_armed", 64'(armed_o), 64'(m_since >= BL));
    chk("m_sticky", 64'(alarm_sticky_o), 64'(m_sticky));
    chk("m_cnt", 64'(alarm_cnt_o), 64'(mc));
    chk("m_first_valid", 64'(first_valid_o), 64'(m_fv));
    chk("m_first_id", 64'(first_id_o), 64'(m_fid));
    chk("m_first_addr", 64'(first_addr_o), 64'(m_faddr));
    chk("m_exit_valid", 64'(exit_valid_o), 64'(m_ev));
    chk("m_exit_value", 64'(exit_value_o), 64'(m_eval));
    chk("m_led", 64'(led_o), 64'(m_led));
  endtask

  // Compare process: sample inputs at the rising edge, check outputs at the falling edge.
  initial forever begin
    @(posedge clk_core_slow_i);
    s_rst = rst_i; s_alarm = alarm_i; s_clear = clear_i; s_addr = instr_addr_i;
    s_ev = exit_valid_i; s_eval = exit_value_i; s_mode = mode_i;
    @(negedge clk_core_slow_i);
    model_step();
    if (m_valid) compare_all();
  end

  task automatic cyc();
    @(negedge clk_core_slow_i);
    #1;
  endtask

  initial begin
    cyc(); cyc();
    // Blanking: alarm 0 held from the first released cycle
    rst_i = 1'b0;
    alarm_i = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      instr_addr_i = 16'h1000 + 16'(c);
      chk($sformatf("blank_armed_c%0d", c), 64'(armed_o), 64'(c >= 7));
      chk($sformatf("blank_sticky0_c%0d", c), 64'(alarm_sticky_o[0]), 64'(c >= 8));
      chk($sformatf("blank_cnt0_c%0d", c), 64'(alarm_cnt_o[0 +: CW]), 64'((c >= 8) ? c - 7 : 0));
      $display("blank cycle %0d armed=%0b sticky=%b cnt0=%0d", c, armed_o, alarm_sticky_o, alarm_cnt_o[0 +: CW]);
      cyc();
    end
    chk("blank_first_addr", 64'(first_addr_o), 64'h1007);
    chk("blank_first_id", 64'(first_id_o), 64'd0);

    // Priority: channels 1 and 3 together
    alarm_i = '0; clear_i = 1'b1; cyc();
    clear_i = 1'b0; alarm_i = 4'b1010; instr_addr_i = 16'h1234; cyc();
    alarm_i = '0;
    chk("prio_first_id", 64'(first_id_o), 64'd1);
    chk("prio_first_addr", 64'(first_addr_o), 64'h1234);
    chk("prio_sticky", 64'(alarm_sticky_o), 64'b1010);
    chk("prio_cnt", 64'(alarm_cnt_o), 64'h1010);
    $display("priority id=%0d addr=%h sticky=%b cnt=%h", first_id_o, first_addr_o, alarm_sticky_o, alarm_cnt_o);
    mode_i = 2'd1; cyc();
    chk("mode1_led", 64'(led_o), 64'h0A);
    mode_i = 2'd0;

    // Saturation of counter 2
    clear_i = 1'b1; cyc();
    clear_i = 1'b0; alarm_i = 4'b0100;
    repeat (20) cyc();
    chk("sat_cnt2", 64'(alarm_cnt_o[2*CW +: CW]), 64'd15);
    repeat (5) cyc();
    chk("sat_cnt2_hold", 64'(alarm_cnt_o[2*CW +: CW]), 64'd15);
    alarm_i = '0; mode_i = 2'd2; cyc();
    chk("mode2_led", 64'(led_o), 64'h0F);
    $display("saturation cnt2=%0d led=%h", alarm_cnt_o[2*CW +: CW], led_o);

    // Clear versus alarm in the same cycle
    clear_i = 1'b1; alarm_i = 4'b0100; cyc();
    clear_i = 1'b0; alarm_i = '0;
    chk("clr_sticky", 64'(alarm_sticky_o), 64'd0);
    chk("clr_cnt", 64'(alarm_cnt_o), 64'd0);
    chk("clr_first_valid", 64'(first_valid_o), 64'd0);
    alarm_i = 4'b1000; instr_addr_i = 16'hBEEF; cyc();
    alarm_i = '0;
    chk("reclr_first_valid", 64'(first_valid_o), 64'd1);
    chk("reclr_first_id", 64'(first_id_o), 64'd3);
    chk("reclr_first_addr", 64'(first_addr_o), 64'hBEEF);
    $display("clear-vs-alarm then new first id=%0d addr=%h", first_id_o, first_addr_o);

    // Exit latch
    exit_valid_i = 1'b1; exit_value_i = 32'hCAFE0001; cyc();
    exit_valid_i = 1'b0; cyc();
    exit_valid_i = 1'b1; exit_value_i = 32'h5; cyc();
    exit_valid_i = 1'b0; mode_i = 2'd3;
    chk("exit_valid", 64'(exit_valid_o), 64'd1);
    chk("exit_value", 64'(exit_value_o), 64'hCAFE0001);
    cyc();
    chk("mode3_led", 64'(led_o), 64'h01);
    $display("exit value=%h led=%h", exit_value_o, led_o);

    // LED fold: A^5^F^4 (low two address bits masked) = 4; sticky, first, exit set, armed
    mode_i = 2'd0; instr_addr_i = 16'hA5F7; cyc();
    chk("fold_nibble", 64'(led_o[3:0]), 64'h4);
    chk("mode0_led", 64'(led_o), 64'h74);
    $display("fold led=%h", led_o);

    // Mid-run reset
    rst_i = 1'b1; cyc();
    chk("rst_armed", 64'(armed_o), 64'd0);
    chk("rst_sticky", 64'(alarm_sticky_o), 64'd0);
    chk("rst_cnt", 64'(alarm_cnt_o), 64'd0);
    chk("rst_first", 64'({first_valid_o, first_id_o, first_addr_o}), 64'd0);
    chk("rst_exit", 64'({exit_valid_o, exit_value_o}), 64'd0);
    chk("rst_led", 64'(led_o), 64'h00);
    rst_i = 1'b0; cyc();
    chk("rst_led_after", 64'(led_o), 64'h84);
    $display("mid-run reset led=%h", led_o);

    // Alarms while unarmed are ignored
    alarm_i = 4'b1111;
    repeat (3) cyc();
    alarm_i = '0; cyc();
    chk("unarmed_sticky", 64'(alarm_sticky_o), 64'd0);
    chk("unarmed_first", 64'(first_valid_o), 64'd0);
    repeat (6) cyc();
    chk("rearmed", 64'(armed_o), 64'd1);
    $display("rearm armed=%0b", armed_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
